// File: rtl/retire_stage_if.sv
// retire_stage_if: committed-store memory port.
//   master (retire stage): drives st_req, st_addr, st_data, st_size; samples st_ack.
//   slave  (memory)      : samples the request; drives st_ack.
// The request is level-held with stable addr/data/size until st_ack is seen.
interface retire_stage_if #(
  parameter int XLEN = 32
) ();
  logic            st_req;
  logic [XLEN-1:0] st_addr;
  logic [XLEN-1:0] st_data;
  logic [1:0]      st_size;
  logic            st_ack;

  modport master (output st_req, output st_addr, output st_data, output st_size, input st_ack);
  modport slave  (input st_req, input st_addr, input st_data, input st_size, output st_ack);
endinterface

// File: rtl/retire_stage.sv
// retire_stage: in-order retire of the ROB head entry.
//   Commit C = retire_en && !ir_stall; the ROB pops its head in that cycle.
//   One cycle after C: free old tag, update arch map, emit commit trace,
//   bump retired_count, latch sticky halt.
//   Stores go through a 3-state FSM (IDLE -> ST_REQ -> ST_DONE) on the st port;
//   the store entry is held (ir_stall) until its ack, then commits from ST_DONE.
// Ports:
//   clock, reset         : single clock, synchronous active-high reset
//   retire_en, retire_t, retire_t_old, halt, wr_mem, take_branch,
//   dest_reg_idx, mem_size, NPC, result, rs2_value : ROB head entry
//   ir_stall             : combinational back-pressure to the ROB
//   free_en/free_tag     : free-list return
//   amt_wr_en/idx/tag    : architectural map update
//   st                   : store port (retire_stage_if.master)
//   retire_valid/NPC/data/reg_idx : commit trace
//   halted, retired_count: sticky halt, commit counter (wraps)
// Option: define RETIRE_SQUASH_EN to add squash_en/squash_pc, a one-cycle
//   pulse after committing a taken branch (squash_pc = result).
module retire_stage #(
  parameter int PREG_W = 6,
  parameter int XLEN   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              retire_en,
  input  logic [PREG_W:0]   retire_t,
  input  logic [PREG_W:0]   retire_t_old,
  input  logic              halt,
  input  logic              wr_mem,
  input  logic              take_branch,
  input  logic [4:0]        dest_reg_idx,
  input  logic [1:0]        mem_size,
  input  logic [XLEN-1:0]   NPC,
  input  logic [XLEN-1:0]   result,
  input  logic [XLEN-1:0]   rs2_value,
  output logic              ir_stall,
  output logic              free_en,
  output logic [PREG_W-1:0] free_tag,
  output logic              amt_wr_en,
  output logic [4:0]        amt_wr_idx,
  output logic [PREG_W-1:0] amt_wr_tag,
  retire_stage_if.master    st,
  output logic              retire_valid,
  output logic [XLEN-1:0]   retire_NPC,
  output logic [XLEN-1:0]   retire_data,
  output logic [4:0]        retire_reg_idx,
  output logic              halted,
  output logic [31:0]       retired_count
`ifdef RETIRE_SQUASH_EN
  ,
  output logic              squash_en,
  output logic [XLEN-1:0]   squash_pc
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              st_req_q, st_req_d;
  logic [XLEN-1:0]   st_addr_q, st_addr_d;
  logic [XLEN-1:0]   st_data_q, st_data_d;
  logic [1:0]        st_size_q, st_size_d;
  logic              free_en_q, free_en_d;
  logic [PREG_W-1:0] free_tag_q, free_tag_d;
  logic              amt_wr_en_q, amt_wr_en_d;
  logic [4:0]        amt_wr_idx_q, amt_wr_idx_d;
  logic [PREG_W-1:0] amt_wr_tag_q, amt_wr_tag_d;
  logic              retire_valid_q, retire_valid_d;
  logic [XLEN-1:0]   retire_npc_q, retire_npc_d;
  logic [XLEN-1:0]   retire_data_q, retire_data_d;
  logic [4:0]        retire_reg_idx_q, retire_reg_idx_d;
  logic              halted_q, halted_d;
  logic [31:0]       retired_count_q, retired_count_d;
  logic              commit;

  // A store head stalls from the cycle it appears until the cycle after its
  // ack; ST_DONE is the one cycle in which the store entry is allowed to commit.
  assign ir_stall = halted_q
                  | ((state_q == IDLE) & retire_en & wr_mem)
                  | (state_q == ST_REQ);
  assign commit   = retire_en & ~ir_stall;

  always_comb begin
    state_d          = state_q;
    st_req_d         = st_req_q;
    st_addr_d        = st_addr_q;
    st_data_d        = st_data_q;
    st_size_d        = st_size_q;
    free_en_d        = 1'b0;
    free_tag_d       = free_tag_q;
    amt_wr_en_d      = 1'b0;
    amt_wr_idx_d     = amt_wr_idx_q;
    amt_wr_tag_d     = amt_wr_tag_q;
    retire_valid_d   = 1'b0;
    retire_npc_d     = retire_npc_q;
    retire_data_d    = retire_data_q;
    retire_reg_idx_d = retire_reg_idx_q;
    halted_d         = halted_q;
    retired_count_d  = retired_count_q;

    unique case (state_q)
      IDLE: begin
        if (retire_en && wr_mem && !halted_q) begin
          state_d   = ST_REQ;
          st_req_d  = 1'b1;
          st_addr_d = result;
          st_data_d = rs2_value;
          st_size_d = mem_size;
        end
      end
      ST_REQ: begin
        if (st.st_ack) begin
          state_d  = ST_DONE;
          st_req_d = 1'b0;
        end
      end
      ST_DONE: state_d = IDLE;
      default: begin
        state_d  = IDLE;
        st_req_d = 1'b0;
      end
    endcase

    if (commit) begin
      free_en_d        = retire_t_old[PREG_W];
      free_tag_d       = retire_t_old[PREG_W-1:0];
      amt_wr_en_d      = retire_t[PREG_W] && (dest_reg_idx != 5'd0) && !halt;
      amt_wr_idx_d     = dest_reg_idx;
      amt_wr_tag_d     = retire_t[PREG_W-1:0];
      retire_valid_d   = 1'b1;
      retire_npc_d     = NPC;
      retire_data_d    = result;
      retire_reg_idx_d = dest_reg_idx;
      retired_count_d  = retired_count_q + 32'd1;
      if (halt) halted_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      st_req_q         <= 1'b0;
      st_addr_q        <= '0;
      st_data_q        <= '0;
      st_size_q        <= '0;
      free_en_q        <= 1'b0;
      free_tag_q       <= '0;
      amt_wr_en_q      <= 1'b0;
      amt_wr_idx_q     <= '0;
      amt_wr_tag_q     <= '0;
      retire_valid_q   <= 1'b0;
      retire_npc_q     <= '0;
      retire_data_q    <= '0;
      retire_reg_idx_q <= '0;
      halted_q         <= 1'b0;
      retired_count_q  <= '0;
    end else begin
      state_q          <= state_d;
      st_req_q         <= st_req_d;
      st_addr_q        <= st_addr_d;
      st_data_q        <= st_data_d;
      st_size_q        <= st_size_d;
      free_en_q        <= free_en_d;
      free_tag_q       <= free_tag_d;
      amt_wr_en_q      <= amt_wr_en_d;
      amt_wr_idx_q     <= amt_wr_idx_d;
      amt_wr_tag_q     <= amt_wr_tag_d;
      retire_valid_q   <= retire_valid_d;
      retire_npc_q     <= retire_npc_d;
      retire_data_q    <= retire_data_d;
      retire_reg_idx_q <= retire_reg_idx_d;
      halted_q         <= halted_d;
      retired_count_q  <= retired_count_d;
    end
  end

  assign st.st_req      = st_req_q;
  assign st.st_addr     = st_addr_q;
  assign st.st_data     = st_data_q;
  assign st.st_size     = st_size_q;
  assign free_en        = free_en_q;
  assign free_tag       = free_tag_q;
  assign amt_wr_en      = amt_wr_en_q;
  assign amt_wr_idx     = amt_wr_idx_q;
  assign amt_wr_tag     = amt_wr_tag_q;
  assign retire_valid   = retire_valid_q;
  assign retire_NPC     = retire_npc_q;
  assign retire_data    = retire_data_q;
  assign retire_reg_idx = retire_reg_idx_q;
  assign halted         = halted_q;
  assign retired_count  = retired_count_q;

`ifdef RETIRE_SQUASH_EN
  logic            squash_en_q, squash_en_d;
  logic [XLEN-1:0] squash_pc_q, squash_pc_d;

  always_comb begin
    squash_en_d = 1'b0;
    squash_pc_d = squash_pc_q;
    if (commit && take_branch) begin
      squash_en_d = 1'b1;
      squash_pc_d = result;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      squash_en_q <= 1'b0;
      squash_pc_q <= '0;
    end else begin
      squash_en_q <= squash_en_d;
      squash_pc_q <= squash_pc_d;
    end
  end

  assign squash_en = squash_en_q;
  assign squash_pc = squash_pc_q;
`else
  // Branch outcome is not acted on in this build.
  logic unused_take_branch;
  assign unused_take_branch = take_branch;
`endif

endmodule

// File: tb/tb_retire_stage.sv
// Bench for retire_stage: vector table for single-cycle commits, hand-written
// store / halt / reset / squash sequences, and a randomized ROB-head stream
// checked against a queue-based model of the commit rules.
module tb_retire_stage;
  localparam int PREG_W = 6;
  localparam int XLEN   = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              retire_en;
  logic [PREG_W:0]   retire_t, retire_t_old;
  logic              halt, wr_mem, take_branch;
  logic [4:0]        dest_reg_idx;
  logic [1:0]        mem_size;
  logic [XLEN-1:0]   NPC, result, rs2_value;
  logic              ir_stall;
  logic              free_en;
  logic [PREG_W-1:0] free_tag;
  logic              amt_wr_en;
  logic [4:0]        amt_wr_idx;
  logic [PREG_W-1:0] amt_wr_tag;
  logic              retire_valid;
  logic [XLEN-1:0]   retire_NPC, retire_data;
  logic [4:0]        retire_reg_idx;
  logic              halted;
  logic [31:0]       retired_count;
  logic              st_ack;
`ifdef RETIRE_SQUASH_EN
  logic              squash_en;
  logic [XLEN-1:0]   squash_pc;
`endif

  retire_stage_if #(.XLEN(XLEN)) st_if ();
  assign st_if.st_ack = st_ack;

  retire_stage #(.PREG_W(PREG_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .retire_en(retire_en),
    .retire_t(retire_t), .retire_t_old(retire_t_old),
    .halt(halt), .wr_mem(wr_mem), .take_branch(take_branch),
    .dest_reg_idx(dest_reg_idx), .mem_size(mem_size),
    .NPC(NPC), .result(result), .rs2_value(rs2_value),
    .ir_stall(ir_stall), .free_en(free_en), .free_tag(free_tag),
    .amt_wr_en(amt_wr_en), .amt_wr_idx(amt_wr_idx), .amt_wr_tag(amt_wr_tag),
    .st(st_if.master),
    .retire_valid(retire_valid), .retire_NPC(retire_NPC),
    .retire_data(retire_data), .retire_reg_idx(retire_reg_idx),
    .halted(halted), .retired_count(retired_count)
`ifdef RETIRE_SQUASH_EN
    , .squash_en(squash_en), .squash_pc(squash_pc)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [PREG_W:0] t, told;
    logic            halt, wr, br;
    logic [4:0]      dest;
    logic [1:0]      size;
    logic [31:0]     npc, res, rs2;
  } head_t;

  typedef struct {
    logic            en;
    logic [PREG_W:0] t, told;
    logic [4:0]      dest;
    logic [31:0]     npc, res;
    logic            fe;
    logic [5:0]      ft;
    logic            ae;
    logic [4:0]      ai;
    logic [5:0]      at;
    logic            rv;
    logic [31:0]     cnt;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input head_t h, input logic en);
    retire_en    = en;
    retire_t     = h.t;
    retire_t_old = h.told;
    halt         = h.halt;
    wr_mem       = h.wr;
    take_branch  = h.br;
    dest_reg_idx = h.dest;
    mem_size     = h.size;
    NPC          = h.npc;
    result       = h.res;
    rs2_value    = h.rs2;
  endtask

  function automatic head_t blank();
    head_t h;
    h.t = '0; h.told = '0; h.halt = 1'b0; h.wr = 1'b0; h.br = 1'b0;
    h.dest = '0; h.size = '0; h.npc = '0; h.res = '0; h.rs2 = '0;
    return h;
  endfunction

  // Expected side effects one cycle after committing entry e.
  task automatic chk_commit(input string tag, input head_t e);
    chk({tag, "_rv"},    retire_valid, 1'b1);
    chk({tag, "_fe"},    free_en, e.told[PREG_W]);
    chk({tag, "_ft"},    free_tag, e.told[PREG_W-1:0]);
    chk({tag, "_ae"},    amt_wr_en, e.t[PREG_W] && e.dest != 0 && !e.halt);
    chk({tag, "_ai"},    amt_wr_idx, e.dest);
    chk({tag, "_at"},    amt_wr_tag, e.t[PREG_W-1:0]);
    chk({tag, "_npc"},   retire_NPC, e.npc);
    chk({tag, "_data"},  retire_data, e.res);
    chk({tag, "_ridx"},  retire_reg_idx, e.dest);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_rv0"}, retire_valid, 1'b0);
    chk({tag, "_fe0"}, free_en, 1'b0);
    chk({tag, "_ae0"}, amt_wr_en, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(blank(), 1'b0);
    st_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  vec_t  vt[6];
  head_t h, sh;
  head_t q[$];
  head_t hd, pend_e;
  logic  pend_v, acked, hold, en, exp_stall, cmt;
  int    exp_cnt, nstores, nacks, cyc;

  initial begin
    vt[0] = '{1'b1, 7'h45, 7'h43, 5'd7,  32'h104, 32'h0AA,      1'b1, 6'd3,  1'b1, 5'd7,  6'd5,  1'b1, 32'd1};
    vt[1] = '{1'b1, 7'h4A, 7'h02, 5'd3,  32'h108, 32'h011,      1'b0, 6'd2,  1'b1, 5'd3,  6'd10, 1'b1, 32'd2};
    vt[2] = '{1'b1, 7'h4C, 7'h41, 5'd0,  32'h10C, 32'h022,      1'b1, 6'd1,  1'b0, 5'd0,  6'd12, 1'b1, 32'd3};
    vt[3] = '{1'b1, 7'h09, 7'h7F, 5'd31, 32'h110, 32'h033,      1'b1, 6'd63, 1'b0, 5'd31, 6'd9,  1'b1, 32'd4};
    vt[4] = '{1'b0, 7'h45, 7'h43, 5'd2,  32'h114, 32'h044,      1'b0, 6'd0,  1'b0, 5'd0,  6'd0,  1'b0, 32'd4};
    vt[5] = '{1'b1, 7'h7F, 7'h00, 5'd1,  32'h200, 32'h12345678, 1'b0, 6'd0,  1'b1, 5'd1,  6'd63, 1'b1, 32'd5};

    // ---------------- reset state ----------------
    do_reset();
    chk("rst_count", retired_count, 32'd0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_streq", st_if.st_req, 1'b0);
    chk("rst_rv", retire_valid, 1'b0);
    chk("rst_fe", free_en, 1'b0);
    chk("rst_ae", amt_wr_en, 1'b0);
    chk("rst_stall_idle", ir_stall, 1'b0);
`ifdef RETIRE_SQUASH_EN
    chk("rst_squash", squash_en, 1'b0);
`endif

    // ---------------- vector table, back-to-back ----------------
    for (int i = 0; i <= 6; i++) begin
      if (i > 0) begin
        chk($sformatf("vec%0d_rv", i-1),  retire_valid, vt[i-1].rv);
        chk($sformatf("vec%0d_fe", i-1),  free_en,      vt[i-1].fe);
        chk($sformatf("vec%0d_ae", i-1),  amt_wr_en,    vt[i-1].ae);
        chk($sformatf("vec%0d_cnt", i-1), retired_count, vt[i-1].cnt);
        if (vt[i-1].rv) begin
          chk($sformatf("vec%0d_ft", i-1),   free_tag,       vt[i-1].ft);
          chk($sformatf("vec%0d_ai", i-1),   amt_wr_idx,     vt[i-1].ai);
          chk($sformatf("vec%0d_at", i-1),   amt_wr_tag,     vt[i-1].at);
          chk($sformatf("vec%0d_npc", i-1),  retire_NPC,     vt[i-1].npc);
          chk($sformatf("vec%0d_data", i-1), retire_data,    vt[i-1].res);
          chk($sformatf("vec%0d_ridx", i-1), retire_reg_idx, vt[i-1].dest);
        end
      end
      if (i < 6) begin
        h = blank();
        h.t = vt[i].t; h.told = vt[i].told; h.dest = vt[i].dest;
        h.npc = vt[i].npc; h.res = vt[i].res;
        drive(h, vt[i].en);
        #1;
        chk($sformatf("vec%0d_stall", i), ir_stall, 1'b0);
        step();
      end
    end
    exp_cnt = 5;

    // ---------------- store, ack on 4th request cycle ----------------
    sh = blank();
    sh.wr = 1'b1; sh.res = 32'h1000; sh.rs2 = 32'hDEADBEEF; sh.size = 2'd2;
    sh.t = 7'h48; sh.told = 7'h44; sh.dest = 5'd9; sh.npc = 32'h300;
    drive(sh, 1'b1);
    st_ack = 1'b1;                     // ack before any request: must be ignored
    #1;
    chk("st_stall_idle", ir_stall, 1'b1);
    chk("st_req_idle", st_if.st_req, 1'b0);
    step();
    st_ack = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("st_req_c%0d", k), st_if.st_req, 1'b1);
      chk($sformatf("st_addr_c%0d", k), st_if.st_addr, 32'h1000);
      chk($sformatf("st_data_c%0d", k), st_if.st_data, 32'hDEADBEEF);
      chk($sformatf("st_size_c%0d", k), st_if.st_size, 2'd2);
      chk($sformatf("st_stall_c%0d", k), ir_stall, 1'b1);
      chk($sformatf("st_norv_c%0d", k), retire_valid, 1'b0);
      if (k == 4) st_ack = 1'b1;
      step();
    end
    st_ack = 1'b0;
    #1;
    chk("st_done_req", st_if.st_req, 1'b0);
    chk("st_done_stall", ir_stall, 1'b0);
    chk("st_done_rv", retire_valid, 1'b0);
    step();
    drive(blank(), 1'b0);
    exp_cnt++;
    chk_commit("st_commit", sh);
    chk("st_cnt", retired_count, exp_cnt);
    step();
    chk_quiet("st_after");
    chk("st_cnt_once", retired_count, exp_cnt);
    chk("st_req_after", st_if.st_req, 1'b0);

`ifdef RETIRE_SQUASH_EN
    // ---------------- taken branch -> squash pulse ----------------
    h = blank();
    h.br = 1'b1; h.res = 32'h200; h.npc = 32'h400; h.t = 7'h43; h.dest = 5'd4;
    drive(h, 1'b1);
    step();
    drive(blank(), 1'b0);
    exp_cnt++;
    chk("sq_en", squash_en, 1'b1);
    chk("sq_pc", squash_pc, 32'h200);
    chk_commit("sq_commit", h);
    step();
    chk("sq_en_drop", squash_en, 1'b0);
`endif

    // ---------------- reset mid-store ----------------
    drive(sh, 1'b1);
    step();
    step();
    chk("mid_req_up", st_if.st_req, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(blank(), 1'b0);
    chk("mid_req_drop", st_if.st_req, 1'b0);
    chk("mid_cnt", retired_count, 32'd0);
    step();
    chk("mid_req_stays", st_if.st_req, 1'b0);
    chk_quiet("mid");

    // ---------------- halt, then hold a store head ----------------
    h = blank();
    h.halt = 1'b1; h.t = 7'h42; h.told = 7'h46; h.dest = 5'd5; h.npc = 32'h500;
    drive(h, 1'b1);
    step();
    chk_commit("halt_commit", h);
    chk("halt_set", halted, 1'b1);
    chk("halt_cnt", retired_count, 32'd1);
    drive(sh, 1'b1);
    st_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("halt_stall%0d", k), ir_stall, 1'b1);
      step();
      chk($sformatf("halt_noreq%0d", k), st_if.st_req, 1'b0);
      chk($sformatf("halt_cnt%0d", k), retired_count, 32'd1);
      chk($sformatf("halt_norv%0d", k), retire_valid, 1'b0);
      chk($sformatf("halt_sticky%0d", k), halted, 1'b1);
    end
    do_reset();
    chk("halt_rst_halted", halted, 1'b0);
    chk("halt_rst_cnt", retired_count, 32'd0);

    // ---------------- randomized ROB stream vs model ----------------
    nstores = 0;
    for (int n = 0; n < 200; n++) begin
      hd = blank();
      hd.t    = 7'($urandom);
      hd.told = 7'($urandom);
      hd.dest = 5'($urandom);
      hd.npc  = $urandom;
      hd.res  = $urandom;
      hd.rs2  = $urandom;
      hd.size = 2'($urandom);
      hd.wr   = ($urandom_range(0, 3) == 0);
      if (hd.wr) nstores++;
      q.push_back(hd);
    end
    exp_cnt = 0; nacks = 0; pend_v = 1'b0; acked = 1'b0; hold = 1'b0; cyc = 0;
    while (cyc < 4000 && (q.size() > 0 || pend_v)) begin
      cyc++;
      chk("rnd_rv", retire_valid, pend_v);
      if (pend_v) chk_commit("rnd", pend_e);
      else begin
        chk("rnd_fe0", free_en, 1'b0);
        chk("rnd_ae0", amt_wr_en, 1'b0);
      end
      chk("rnd_cnt", retired_count, exp_cnt);
      pend_v = 1'b0;
      if (q.size() > 0) begin
        hd = q[0];
        en = hold || ($urandom_range(0, 3) != 0);
      end else begin
        hd = blank();
        en = 1'b0;
      end
      drive(hd, en);
      st_ack = ($urandom_range(0, 2) == 0);
      #1;
      // A store stays stalled until the cycle after its ack.
      exp_stall = en && hd.wr && !acked;
      chk("rnd_stall", ir_stall, exp_stall);
      if (st_if.st_req && st_ack) begin
        nacks++;
        chk("rnd_ack_is_store", hd.wr && !acked, 1'b1);
        chk("rnd_st_addr", st_if.st_addr, hd.res);
        chk("rnd_st_data", st_if.st_data, hd.rs2);
        chk("rnd_st_size", st_if.st_size, hd.size);
        acked = 1'b1;
      end
      cmt = en && !exp_stall;
      if (cmt) begin
        pend_v = 1'b1;
        pend_e = hd;
        void'(q.pop_front());
        exp_cnt++;
        acked = 1'b0;
        hold = 1'b0;
      end else if (en && hd.wr) begin
        hold = 1'b1;
      end
      step();
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_store_acks", nacks, nstores);
    chk("rnd_final_cnt", retired_count, 32'd200);
    chk("rnd_not_halted", halted, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
